uart_tx_fifo: RTL and testbench

//   Byte FIFO plus transmit sequencer feeding the uart block's tx_data/tx_start/tx_busy.

---
 rtl/uart_tx_fifo_pkg.sv | 11 +
 rtl/uart_tx_fifo_sync_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 80 ++++++++
 tb/tb_uart_tx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART transmit-side definitions: byte width and sequencer state encoding.
package uart_tx_fifo_pkg;
  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy, full and empty flags.
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   level_next;
  logic              wr_ok;
  logic              rd_ok;

  // full/empty are the registered flags, so a write while full is dropped
  // even when a pop frees a slot on the same edge.
  assign wr_ok   = wr && !full;
  assign rd_ok   = rd && !empty;
  assign rd_data = mem[rptr];

  always_comb begin
    level_next = level;
    if (wr_ok && !rd_ok)
      level_next = level + (ADDR_W+1)'(1);
    else if (rd_ok && !wr_ok)
      level_next = level - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_ok) wptr <= wptr + ADDR_W'(1);
      if (rd_ok) rptr <= rptr + ADDR_W'(1);
      level <= level_next;
      full  <= (level_next == (ADDR_W+1)'(DEPTH));
      empty <= (level_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus transmit sequencer: drains queued bytes into the uart one at a time.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_en,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic [UART_BYTE_W-1:0] tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy
);
  tx_state_t             state_reg;
  tx_state_t             state_next;
  logic                  pop;
  logic [UART_BYTE_W-1:0] rd_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_BYTE_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .wr      (wr_en),
    .wr_data (wr_data),
    .rd      (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      tx_data   <= '0;
      overflow  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop) tx_data <= rd_data;
      if (wr_en && full)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  // GUARD skips one tx_busy sample to cover the uart's busy-rise latency.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    tx_start   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        tx_start   = 1'b1;
        state_next = ST_GUARD;
      end
      ST_GUARD: state_next = ST_WAIT;
      ST_WAIT: begin
        if (!tx_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo with a queue-based reference model.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       full, empty, overflow, tx_start, tx_busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  logic       ext_busy = 1'b0;
  int         uart_cnt = 0;

  int         n_tests = 0;
  int         n_fail = 0;
  int         pulses = 0;
  int         model_cnt = 0;
  bit         model_ovf = 0;
  byte unsigned exp_q[$];
  logic [7:0] last_byte = '0;
  logic       prev_busy = 1'b0;
  logic       prev_start = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  always #20 CLK = ~CLK;

  // Simple uart: busy for 10 cycles after each start pulse.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) uart_cnt <= 0;
    else if (tx_start) uart_cnt <= 10;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
  end
  assign tx_busy = ext_busy | (uart_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe the uart side: ordering, pulse spacing, and data hold during frames.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (tx_start) begin
        pulses++;
        chk("pulse_after_busy", {31'b0, prev_busy}, 0);
        chk("pulse_width", {31'b0, prev_start}, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_pulse", 1, 0);
        end else begin
          last_byte = exp_q.pop_front();
          model_cnt--;
          chk("tx_data_order", {24'b0, tx_data}, {24'b0, last_byte});
          $display("[TB] tx byte %02h", tx_data);
        end
      end else if (uart_cnt != 0) begin
        chk("tx_data_hold", {24'b0, tx_data}, {24'b0, last_byte});
      end
    end
    prev_busy  = tx_busy;
    prev_start = tx_start;
  end

  // Called at a negedge; returns at the following negedge.
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge CLK);
    if (model_cnt < DEPTH) begin
      exp_q.push_back(b);
      model_cnt++;
    end else begin
      model_ovf = 1;
    end
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || uart_cnt != 0) && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    chk("drain_timeout", {31'b0, t < 3000}, 1);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    byte unsigned hello[5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    int p0;
    int t;
    int sent;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_level", {27'b0, level}, 0);
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    chk("rst_start", {31'b0, tx_start}, 0);
    chk("rst_data", {24'b0, tx_data}, 0);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: "hello" back-to-back
    p0 = pulses;
    for (int i = 0; i < 5; i++) write_byte(hello[i]);
    drain();
    chk("t1_pulses", pulses - p0, 5);

    // 2: 17 writes with uart held busy
    ext_busy = 1'b1;
    for (int i = 0; i <= 16; i++) write_byte(8'(i));
    chk("t2_level", {27'b0, level}, model_cnt);
    chk("t2_full", {31'b0, full}, 1);
    chk("t2_ovf", {31'b0, overflow}, {31'b0, model_ovf});

    // 3: overflow set beats clear, then clear alone
    wr_en = 1'b1; wr_data = 8'h55; clr_ovf = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    wr_en = 1'b0;
    chk("t3_set_wins", {31'b0, overflow}, 1);
    @(posedge CLK);
    @(negedge CLK);
    clr_ovf = 1'b0;
    chk("t3_cleared", {31'b0, overflow}, 0);
    model_ovf = 0;
    p0 = pulses;
    ext_busy = 1'b0;
    drain();
    chk("t2_pulses", pulses - p0, 16);

    // 4: reset during WAIT with bytes still queued
    for (int i = 0; i < 4; i++) write_byte(8'hC0 + 8'(i));
    t = 0;
    while (uart_cnt == 0 && t < 100) begin @(negedge CLK); t++; end
    chk("t4_start_timeout", {31'b0, t < 100}, 1);
    repeat (3) @(negedge CLK);
    #5 RESET = 1'b1;
    #1;
    chk("t4_start", {31'b0, tx_start}, 0);
    chk("t4_level", {27'b0, level}, 0);
    chk("t4_empty", {31'b0, empty}, 1);
    exp_q.delete();
    model_cnt = 0;
    @(negedge CLK);
    RESET = 1'b0;
    p0 = pulses;
    repeat (30) @(negedge CLK);
    chk("t4_no_pulse", pulses - p0, 0);

    // 5: single-byte latency
    wr_en = 1'b1; wr_data = 8'hA5;
    @(posedge CLK);
    exp_q.push_back(8'hA5);
    model_cnt++;
    #1 chk("t5_n", {31'b0, tx_start}, 0);
    @(negedge CLK) wr_en = 1'b0;
    @(posedge CLK);
    #1 chk("t5_n1", {31'b0, tx_start}, 1);
    chk("t5_data", {24'b0, tx_data}, 8'hA5);
    @(posedge CLK);
    #1 chk("t5_n2", {31'b0, tx_start}, 0);
    @(negedge CLK);
    drain();
    chk("t5_hold_after", {24'b0, tx_data}, 8'hA5);

    // 6: randomized streaming across pointer wrap
    sent = 0;
    while (sent < 40) begin
      for (int b = $urandom_range(1, 6); b > 0 && sent < 40; b--) begin
        write_byte(8'($urandom));
        sent++;
      end
      repeat ($urandom_range(0, 12)) @(negedge CLK);
      t = 0;
      while (model_cnt > 10 && t < 1000) begin @(negedge CLK); t++; end
      chk("t6_backoff_timeout", {31'b0, t < 1000}, 1);
      chk("t6_level_max", {31'b0, level <= 5'd16}, 1);
    end
    drain();
    chk("t6_ovf", {31'b0, overflow}, {31'b0, model_ovf});
    chk("t6_empty", {31'b0, empty}, 1);
    chk("t6_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
